// File: rtl/irq_controller.sv
// Prioritised interrupt controller sitting in front of a single processor IRQ line.
// Synchronises the raw request lines, latches edge-type requests, masks them with
// a software enable and hands one source at a time to the processor through an
// assert / acknowledge / end-of-interrupt handshake.
`timescale 1ns/1ps

module irq_controller #(
    parameter int                    NumSources = 8,
    parameter int                    IdWidth    = 3,
    parameter logic [NumSources-1:0] EdgeMask   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic [NumSources-1:0] irq_src,
    input  logic                  irq_ack,
    input  logic                  irq_eoi,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    output logic                  IRQ,
    output logic [IdWidth-1:0]    irq_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [NumSources-1:0] r_s1;
    logic [NumSources-1:0] r_s2;
    logic [NumSources-1:0] r_s2_d;
    logic [NumSources-1:0] r_pending;
    logic [NumSources-1:0] r_enable;
    state_t                r_state;
    logic                  r_irq;
    logic [IdWidth-1:0]    r_id;

    state_t                w_state_next;
    logic [IdWidth-1:0]    w_id_next;
    logic                  w_ack_take;
    logic [NumSources-1:0] w_req;
    logic [IdWidth-1:0]    w_winner;
    logic [NumSources-1:0] w_set;
    logic [NumSources-1:0] w_clr;
    logic [NumSources-1:0] w_pending_next;
    logic                  w_wr_enable;
    logic                  w_wr_w1c;
    logic                  w_wr_softset;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // Lowest set index wins; scanning downwards leaves the lowest index last.
    function automatic logic [IdWidth-1:0] f_lowest_index(input logic [NumSources-1:0] vec);
        logic [IdWidth-1:0] idx;
        idx = {IdWidth{1'b0}};
        for (int i = NumSources - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IdWidth'(i);
            end
        end
        return idx;
    endfunction

    assign w_wr_enable  = cfg_we && (cfg_addr == 2'd0);
    assign w_wr_w1c     = cfg_we && (cfg_addr == 2'd1);
    assign w_wr_softset = cfg_we && (cfg_addr == 2'd3);
    assign w_req        = r_pending & r_enable;
    assign w_winner     = f_lowest_index(w_req);
    // Write-data bits above NumSources have no register behind them.
    assign w_unused     = &{1'b0, cfg_wdata};

    // Two-flop synchroniser per line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1   <= {NumSources{1'b0}};
            r_s2   <= {NumSources{1'b0}};
            r_s2_d <= {NumSources{1'b0}};
        end else begin
            r_s1   <= irq_src;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // Pending next-state: edge bits set by hw edge or SOFTSET, cleared by ack or W1C,
    // with set taking priority so no edge is lost; level bits simply follow the line.
    always_comb begin
        w_set          = {NumSources{1'b0}};
        w_clr          = {NumSources{1'b0}};
        w_pending_next = r_pending;
        for (int i = 0; i < NumSources; i++) begin
            w_set[i] = (r_s2[i] & ~r_s2_d[i]) | (w_wr_softset & cfg_wdata[i]);
            w_clr[i] = (w_ack_take && (r_id == IdWidth'(i))) | (w_wr_w1c & cfg_wdata[i]);
            if (EdgeMask[i]) begin
                if (w_set[i]) begin
                    w_pending_next[i] = 1'b1;
                end else if (w_clr[i]) begin
                    w_pending_next[i] = 1'b0;
                end else begin
                    w_pending_next[i] = r_pending[i];
                end
            end else begin
                w_pending_next[i] = r_s2[i];
            end
        end
    end

    // Pending request register.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= {NumSources{1'b0}};
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Software enable mask.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_enable <= {NumSources{1'b0}};
        end else if (w_wr_enable) begin
            r_enable <= cfg_wdata[NumSources-1:0];
        end else begin
            r_enable <= r_enable;
        end
    end

    // Handshake FSM next state: arbitrate only in IDLE, one interrupt in flight at a time.
    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_next = ST_ASSERT;
                    w_id_next    = w_winner;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (irq_ack) begin
                    w_state_next = ST_SERVICE;
                    w_ack_take   = 1'b1;
                end else begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_SERVICE: begin
                if (irq_eoi) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SERVICE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched source id and registered IRQ output.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_id    <= {IdWidth{1'b0}};
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_id    <= w_id_next;
            r_irq   <= (w_state_next == ST_ASSERT);
        end
    end

    // Config read mux; unused bits read as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (cfg_addr)
            2'd0: w_rdata[NumSources-1:0] = r_enable;
            2'd1: w_rdata[NumSources-1:0] = r_pending;
            2'd2: begin
                w_rdata[IdWidth-1:0] = r_id;
                w_rdata[17:16]       = r_state;
                w_rdata[31]          = r_irq;
            end
            2'd3: w_rdata = 32'd0;
            default: w_rdata = 32'd0;
        endcase
    end

    assign cfg_rdata = w_rdata;
    assign IRQ       = r_irq;
    assign irq_id    = r_id;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-written sequences for latency, priority,
// edge/level behaviour, config and async reset, plus a per-cycle vector table for
// the handshake corner cases.
`timescale 1ns/1ps

module tb_irq_controller;

    logic        clk;
    logic        RESET_N;
    logic [7:0]  irq_src;
    logic        irq_ack;
    logic        irq_eoi;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        IRQ;
    logic [2:0]  irq_id;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        ack;
        logic        eoi;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        exp_irq;
        logic [1:0]  exp_state;
        logic [7:0]  exp_pend;
    } vec_t;

    vec_t tbl[19];

    irq_controller #(
        .NumSources(8),
        .IdWidth   (3),
        .EdgeMask  (8'h0F)
    ) dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .irq_src  (irq_src),
        .irq_ack  (irq_ack),
        .irq_eoi  (irq_eoi),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .IRQ      (IRQ),
        .irq_id   (irq_id)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_we   = 1'b0;
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        cyc(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi = 1'b1;
        cyc(1);
        irq_eoi = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        RESET_N   = 1'b0;
        irq_src   = 8'h00;
        irq_ack   = 1'b0;
        irq_eoi   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'd0;

        //          ack   eoi   we    addr  wdata   irq   state pend
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00}; // ack in IDLE
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00}; // eoi in IDLE
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd3, 32'd8, 1'b0, 2'd0, 8'h08}; // softset src3
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 8'h08};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 8'h08}; // eoi in ASSERT
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd2, 8'h00}; // ack+eoi
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd2, 8'h00}; // ack in SERVICE
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00}; // disable all
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 32'd8, 1'b0, 2'd0, 8'h08};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h08}; // masked
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'd8, 1'b0, 2'd0, 8'h08}; // enable src3
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 8'h08};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1, 2'd1, 8'h08}; // disable in ASSERT
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 8'h08};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd2, 8'h00};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 8'h00};

        // Reset state and first-request latency.
        cyc(3);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        rd_chk("rst_status", 2'd2, 32'd0);
        rd_chk("rst_enable", 2'd0, 32'd0);
        rd_chk("rst_pending", 2'd1, 32'd0);
        RESET_N = 1'b1;
        cyc(1);
        cfg_write(2'd0, 32'h0000_0004);
        irq_src = 8'h04;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("lat_early_irq", 32'(IRQ), 32'd0);
        end
        cyc(1);
        chk("lat_irq", 32'(IRQ), 32'd1);
        chk("lat_id", 32'(irq_id), 32'd2);
        rd_chk("lat_status", 2'd2, 32'h8001_0002);
        pulse_ack();
        rd_chk("ack_pending", 2'd1, 32'd0);
        rd_chk("ack_status", 2'd2, 32'h0002_0002);
        pulse_eoi();
        rd_chk("eoi_status", 2'd2, 32'h0000_0002);
        irq_src = 8'h00;
        cyc(4);

        // Priority and no nesting.
        cfg_write(2'd0, 32'h0000_00FF);
        irq_src = 8'h22;
        cyc(4);
        chk("prio_irq", 32'(IRQ), 32'd1);
        chk("prio_id", 32'(irq_id), 32'd1);
        pulse_ack();
        chk("prio_ack_irq", 32'(IRQ), 32'd0);
        irq_src = 8'h23;
        cyc(5);
        chk("nonest_irq", 32'(IRQ), 32'd0);
        rd_chk("nonest_status", 2'd2, 32'h0002_0001);
        rd_chk("nonest_pending", 2'd1, 32'h0000_0021);
        pulse_eoi();
        chk("eoi_gap_irq", 32'(IRQ), 32'd0);
        cyc(1);
        chk("next_irq", 32'(IRQ), 32'd1);
        chk("next_id", 32'(irq_id), 32'd0);
        pulse_ack();
        pulse_eoi();
        chk("third_gap_irq", 32'(IRQ), 32'd0);
        cyc(1);
        chk("third_irq", 32'(IRQ), 32'd1);
        chk("third_id", 32'(irq_id), 32'd5);
        pulse_ack();
        irq_src = 8'h00;
        cyc(5);
        pulse_eoi();
        cyc(1);
        chk("prio_done_irq", 32'(IRQ), 32'd0);
        rd_chk("prio_done_pending", 2'd1, 32'd0);

        // Level source re-arms while held; edge pulse is serviced once.
        irq_src = 8'h40;
        cyc(4);
        chk("level_irq", 32'(IRQ), 32'd1);
        chk("level_id", 32'(irq_id), 32'd6);
        pulse_ack();
        pulse_eoi();
        chk("level_gap_irq", 32'(IRQ), 32'd0);
        cyc(1);
        chk("level_rearm_irq", 32'(IRQ), 32'd1);
        chk("level_rearm_id", 32'(irq_id), 32'd6);
        pulse_ack();
        irq_src = 8'h00;
        cyc(5);
        pulse_eoi();
        cyc(1);
        chk("level_drop_irq", 32'(IRQ), 32'd0);
        irq_src = 8'h08;
        cyc(1);
        irq_src = 8'h00;
        cyc(3);
        chk("edge_irq", 32'(IRQ), 32'd1);
        chk("edge_id", 32'(irq_id), 32'd3);
        rd_chk("edge_pending", 2'd1, 32'h0000_0008);
        pulse_ack();
        rd_chk("edge_clr_ack", 2'd1, 32'd0);
        pulse_eoi();
        cyc(1);
        chk("edge_once_a", 32'(IRQ), 32'd0);
        cyc(4);
        chk("edge_once_b", 32'(IRQ), 32'd0);

        // Config: SOFTSET, masking, unused bits, W1C versus hardware edge.
        cfg_write(2'd0, 32'd0);
        cfg_write(2'd3, 32'h0000_0008);
        rd_chk("soft_pending", 2'd1, 32'h0000_0008);
        chk("soft_masked_irq", 32'(IRQ), 32'd0);
        rd_chk("softset_reads0", 2'd3, 32'd0);
        cyc(2);
        chk("soft_masked_irq2", 32'(IRQ), 32'd0);
        cfg_write(2'd0, 32'hFFFF_FF08);
        chk("en_delay_irq", 32'(IRQ), 32'd0);
        rd_chk("en_unused_bits", 2'd0, 32'h0000_0008);
        cyc(1);
        chk("soft_irq", 32'(IRQ), 32'd1);
        chk("soft_id", 32'(irq_id), 32'd3);
        pulse_ack();
        rd_chk("soft_ack_pending", 2'd1, 32'd0);
        cfg_write(2'd3, 32'h0000_0008);
        rd_chk("soft2_pending", 2'd1, 32'h0000_0008);
        irq_src = 8'h08;
        cyc(2);
        cfg_write(2'd1, 32'h0000_0008);
        rd_chk("w1c_vs_edge", 2'd1, 32'h0000_0008);
        cfg_write(2'd1, 32'h0000_0008);
        rd_chk("w1c_clear", 2'd1, 32'd0);
        irq_src = 8'h00;
        pulse_eoi();
        cyc(1);
        chk("cfg_done_irq", 32'(IRQ), 32'd0);

        // Handshake abuse, one table row per clock.
        for (int i = 0; i < 19; i++) begin
            irq_ack   = tbl[i].ack;
            irq_eoi   = tbl[i].eoi;
            cfg_we    = tbl[i].we;
            cfg_addr  = tbl[i].addr;
            cfg_wdata = tbl[i].wdata;
            cyc(1);
            irq_ack = 1'b0;
            irq_eoi = 1'b0;
            rd_chk($sformatf("tbl%0d_status", i), 2'd2,
                   {tbl[i].exp_irq, 13'd0, tbl[i].exp_state, 13'd0, 3'd3});
            rd_chk($sformatf("tbl%0d_pending", i), 2'd1, {24'd0, tbl[i].exp_pend});
            chk($sformatf("tbl%0d_irq", i), 32'(IRQ), 32'(tbl[i].exp_irq));
        end

        // Asynchronous reset in the middle of SERVICE.
        cfg_write(2'd3, 32'h0000_000B);
        cfg_write(2'd0, 32'h0000_00FF);
        cyc(1);
        chk("pre_rst_irq", 32'(IRQ), 32'd1);
        chk("pre_rst_id", 32'(irq_id), 32'd0);
        pulse_ack();
        rd_chk("pre_rst_status", 2'd2, 32'h0002_0000);
        rd_chk("pre_rst_pending", 2'd1, 32'h0000_000A);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("arst_irq", 32'(IRQ), 32'd0);
        chk("arst_id", 32'(irq_id), 32'd0);
        rd_chk("arst_enable", 2'd0, 32'd0);
        rd_chk("arst_pending", 2'd1, 32'd0);
        rd_chk("arst_status", 2'd2, 32'd0);
        RESET_N = 1'b1;
        cyc(2);
        chk("post_rst_irq", 32'(IRQ), 32'd0);
        rd_chk("post_rst_status", 2'd2, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller that sits in front of the Processor's single IRQ input.
- Collects up to NumSources external interrupt lines and synchronises them.
- Latches edge-type requests, applies a software-programmable enable mask, and picks the highest-priority pending source.
- Sequences one interrupt at a time through an assert / acknowledge / end-of-interrupt handshake. The exception handler reads the source id over a small config port.

Parameters:
NumSources, 8, number of interrupt inputs (1..32); index 0 = highest priority
IdWidth, 3, width of source id; must satisfy 2**IdWidth >= NumSources
EdgeMask, 8'hFF, per-source mode: 1 = rising-edge latched, 0 = level

Ports:
clk  input  1  global clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
irq_src  input  NumSources  raw interrupt lines, asynchronous to clk
irq_ack  input  1  one-cycle pulse from processor when it vectors to XAddr
irq_eoi  input  1  one-cycle pulse from handler signalling end of service
cfg_we  input  1  config write strobe
cfg_addr  input  2  config register select
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data, combinational from cfg_addr
IRQ  output  1  registered interrupt request to Processor
irq_id  output  IdWidth  id of asserted/in-service source, registered

Behaviour:
- Reset (RESET_N low, async): IRQ=0, irq_id=0, enable=0, pending=0, synchronisers=0, state=IDLE. Takes effect immediately, including mid-handshake; no pending or in-service state survives.
- Input path: two-flop synchroniser per source (s1, s2), plus registered s2_d.
  - Edge sources: pending bit set on s2 & ~s2_d.
  - Level sources: pending bit = s2 registered each cycle; cannot be cleared by software.
- Latency: source high before clk edge E1. s1 at E1, s2 at E2, pending at E3, IRQ=1 after E4.
- Arbitration: req = pending & enable. Winner = lowest set index. Evaluated only in IDLE.
- State machine (2-bit):
  - IDLE: IRQ=0. If req != 0: latch irq_id = winner, go ASSERT (IRQ=1 next cycle).
  - ASSERT: IRQ=1, irq_id held.
    - On irq_ack: IRQ=0; clear pending[irq_id] if it is an edge source; go SERVICE.
    - Disabling the source in ASSERT does not retract IRQ.
  - SERVICE: IRQ=0, irq_id held. On irq_eoi go IDLE. The earliest next IRQ is 2 cycles after the eoi pulse (1 cycle to reach IDLE, 1 to reach ASSERT).
  - No nesting: higher-priority requests arriving during ASSERT/SERVICE stay pending and win at the next IDLE.
- Spurious handshakes:
  - irq_ack outside ASSERT is ignored.
  - irq_eoi outside SERVICE is ignored.
  - ack and eoi together in ASSERT: ack taken, eoi ignored.
- Config registers (unused bits read 0, writes to them ignored):
  - addr 0 ENABLE: rw, bits [NumSources-1:0].
  - addr 1 PENDING: read returns pending. Write-1-to-clear on edge bits only.
  - addr 2 STATUS: ro. [IdWidth-1:0]=irq_id, [17:16]=state (0 IDLE, 1 ASSERT, 2 SERVICE), [31]=IRQ.
  - addr 3 SOFTSET: wo, reads 0. Write-1 sets pending on edge bits (software interrupt).
- Same-cycle conflicts on one pending bit, for set sources (hw edge, SOFTSET) vs clear sources (ack, W1C): set wins, so no edge is ever lost.
- A write to ENABLE in IDLE takes effect for arbitration in the following cycle.

Test Plan:
- Reset/latency: RESET_N low 3 cycles then high, ENABLE=8'h04, irq_src[2] rises → IRQ=1 and irq_id=2 exactly 4 clk edges after first sample; STATUS reads 0x80010002.
- Priority and no nesting: ENABLE=FF, raise src 5 and src 1 in the same cycle → irq_id=1. Ack, then raise src 0 in SERVICE → IRQ stays 0. eoi → IRQ=1 with irq_id=0 two cycles later, then src 5 after the next ack/eoi.
- Edge vs level: EdgeMask=8'h0F, src 6 held high → re-asserts after each eoi until dropped. Src 3 single pulse → serviced once only; PENDING bit 3 = 0 after ack.
- Config: SOFTSET write 0x08 with ENABLE=0 → PENDING=0x08, IRQ=0. ENABLE=0x08 → IRQ=1, id=3. W1C of PENDING 0x08 in the same cycle as a new hw edge on src 3 → bit stays 1.
- Handshake abuse: ack in IDLE, eoi in ASSERT, and ack+eoi together → state moves only as specified (IDLE, ASSERT→SERVICE respectively).
- Async reset mid-SERVICE: drop RESET_N between clock edges → IRQ, irq_id, ENABLE, PENDING read 0 before the next clk edge; state IDLE.
